// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO stage: bus command encoding,
// address-region tags and default IO addresses.
package mem_io_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10,
        MRSVD  = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_UNMAPPED
    } region_e;

    localparam logic [8:0] DEF_LED_ADDR = 9'h100;
    localparam logic [8:0] DEF_SW_ADDR  = 9'h140;

endpackage

// File: rtl/ram_sync.sv
// Single-port RAM with synchronous write and a registered, enabled read port.
module ram_sync #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; the array contents survive reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_io_unit.sv
// Memory/IO stage: RAM, memory-mapped LED register, synchronised switch port
// and a sticky flag for unmapped or reserved bus accesses.
module mem_io_unit
    import mem_io_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 9,
    parameter int                RAM_WORDS = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR  = DEF_LED_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR   = DEF_SW_ADDR
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    input  logic [7:0]        SW,
    output logic [7:0]        LEDR,
    output logic              bus_err
);

    localparam int          IDX_W    = $clog2(RAM_WORDS);
    localparam int          IO_PAD_W = DATA_W - 8;
    localparam logic [31:0] RAM_TOP  = 32'(RAM_WORDS);

    // IO addresses overlapping RAM or each other would make decode ambiguous.
    if (32'(LED_ADDR) < RAM_TOP || 32'(SW_ADDR) < RAM_TOP || LED_ADDR == SW_ADDR) begin : gMapCheck
        $error("mem_io_unit: LED_ADDR/SW_ADDR must be distinct and outside RAM");
    end

    mem_cmd_e          cmd;
    region_e           region;
    logic [IDX_W-1:0]  ramIdx;
    logic              ramWe;
    logic              ramRe;
    logic [DATA_W-1:0] ramRdata;

    logic [7:0]        led_q,      led_d;
    logic [DATA_W-1:0] ioData_q,   ioData_d;
    logic              rdSelRam_q, rdSelRam_d;
    logic              rdValid_q,  rdValid_d;
    logic              busErr_q,   busErr_d;
    logic [7:0]        swMeta_q;
    logic [7:0]        swSync_q;

    assign cmd    = mem_cmd_e'(mem_cmd);
    assign ramIdx = mem_addr[IDX_W-1:0];

    // Range check comes first so that high addresses can never alias into RAM.
    always_comb begin
        region = REG_UNMAPPED;
        if (32'(mem_addr) < RAM_TOP) begin
            region = REG_RAM;
        end else if (mem_addr == LED_ADDR) begin
            region = REG_LED;
        end else if (mem_addr == SW_ADDR) begin
            region = REG_SW;
        end
    end

    always_comb begin
        led_d      = led_q;
        ioData_d   = ioData_q;
        rdSelRam_d = rdSelRam_q;
        busErr_d   = busErr_q;
        rdValid_d  = 1'b0;
        ramWe      = 1'b0;
        ramRe      = 1'b0;
        case (cmd)
            MREAD: begin
                rdValid_d  = 1'b1;
                rdSelRam_d = (region == REG_RAM);
                case (region)
                    REG_RAM: ramRe    = 1'b1;
                    REG_LED: ioData_d = {{IO_PAD_W{1'b0}}, led_q};
                    REG_SW:  ioData_d = {{IO_PAD_W{1'b0}}, swSync_q};
                    default: begin
                        ioData_d = '0;
                        busErr_d = 1'b1;
                    end
                endcase
            end
            MWRITE: begin
                case (region)
                    REG_RAM: ramWe    = 1'b1;
                    REG_LED: led_d    = write_data[7:0];
                    default: busErr_d = 1'b1;
                endcase
            end
            MRSVD:   busErr_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q      <= '0;
            ioData_q   <= '0;
            rdSelRam_q <= 1'b0;
            rdValid_q  <= 1'b0;
            busErr_q   <= 1'b0;
            swMeta_q   <= '0;
            swSync_q   <= '0;
        end else begin
            led_q      <= led_d;
            ioData_q   <= ioData_d;
            rdSelRam_q <= rdSelRam_d;
            rdValid_q  <= rdValid_d;
            busErr_q   <= busErr_d;
            swMeta_q   <= SW;
            swSync_q   <= swMeta_q;
        end
    end

    ram_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_WORDS),
        .IDX_W  (IDX_W)
    ) uRam (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (ramIdx),
        .wdata_i (write_data),
        .rdata_o (ramRdata)
    );

    // RAM data already sits in its own read register, so only the source is selected here.
    assign read_data = rdSelRam_q ? ramRdata : ioData_q;
    assign rd_valid  = rdValid_q;
    assign LEDR      = led_q;
    assign bus_err   = busErr_q;

endmodule

// File: tb/tb_mem_io_unit.sv
// Scoreboard bench for mem_io_unit: reads push expected data, a negedge
// monitor pops and compares when rd_valid is due.
module tb_mem_io_unit;
    import mem_io_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;
    logic [7:0]  SW;
    logic [7:0]  LEDR;
    logic        bus_err;

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycle       = 0;
    bit   monitorOn   = 1'b0;
    exp_t sbQ[$];

    mem_io_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .SW         (SW),
        .LEDR       (LEDR),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expRead);
        @(negedge clk);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = wdata;
        if (cmd == MREAD) sbQ.push_back('{data: expRead, due: cycle + 1});
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000);
        settle();
        monitorOn = 1'b0;
        sbQ.delete();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("pulseRstBusErr", bus_err, 0);
        @(negedge clk);
        reset = 1'b0;
        settle();
        monitorOn = 1'b1;
    endtask

    // A read is due exactly one edge after it was driven; anything else is an error.
    always @(negedge clk) begin
        if (monitorOn) begin
            bit expValid;
            expValid = (sbQ.size() > 0) && (sbQ[0].due == cycle);
            checkOutput("rdValid", rd_valid, expValid);
            if (expValid) begin
                checkOutput("readData", read_data, sbQ[0].data);
                void'(sbQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        SW         = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rstReadData", read_data, 0);
        checkOutput("rstRdValid", rd_valid, 0);
        checkOutput("rstLedr", LEDR, 0);
        checkOutput("rstBusErr", bus_err, 0);
        reset = 1'b0;
        settle();
        monitorOn = 1'b1;

        // RAM write then read-after-write, and hold over idle cycles
        applyStimulus(MWRITE, 9'h005, 16'hBEEF, 16'h0000);
        applyStimulus(MREAD,  9'h005, 16'h0000, 16'hBEEF);
        repeat (3) applyStimulus(MNONE, 9'h005, 16'h0000, 16'h0000);
        settle();
        checkOutput("holdBeef", read_data, 16'hBEEF);

        // RAM boundaries
        applyStimulus(MWRITE, 9'h0FE, 16'hCAFE, 16'h0000);
        applyStimulus(MWRITE, 9'h0FF, 16'h1234, 16'h0000);
        applyStimulus(MWRITE, 9'h000, 16'h5678, 16'h0000);
        applyStimulus(MREAD,  9'h0FF, 16'h0000, 16'h1234);
        applyStimulus(MREAD,  9'h000, 16'h0000, 16'h5678);
        applyStimulus(MREAD,  9'h0FE, 16'h0000, 16'hCAFE);
        settle();
        checkOutput("ramBusErr", bus_err, 0);

        // LED register
        applyStimulus(MWRITE, 9'h100, 16'hA5C3, 16'h0000);
        settle();
        checkOutput("ledr", LEDR, 8'hC3);
        applyStimulus(MREAD, 9'h100, 16'h0000, 16'h00C3);

        // Switch synchroniser: change appears to a read on the third edge
        applyStimulus(MREAD, 9'h140, 16'h0000, 16'h0000);
        SW = 8'h5A;
        applyStimulus(MREAD, 9'h140, 16'h0000, 16'h0000);
        applyStimulus(MREAD, 9'h140, 16'h0000, 16'h005A);
        settle();
        checkOutput("swBusErr", bus_err, 0);

        // Unmapped read
        applyStimulus(MREAD, 9'h1FF, 16'h0000, 16'h0000);
        settle();
        checkOutput("unmappedRdErr", bus_err, 1);

        // Write to switch port is ignored and flagged
        pulseReset();
        applyStimulus(MWRITE, 9'h140, 16'h00FF, 16'h0000);
        settle();
        checkOutput("swWriteErr", bus_err, 1);
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000);
        applyStimulus(MREAD, 9'h140, 16'h0000, 16'h005A);

        // Unmapped write must not alias into RAM word 5
        pulseReset();
        applyStimulus(MWRITE, 9'h105, 16'h1111, 16'h0000);
        settle();
        checkOutput("unmappedWrErr", bus_err, 1);
        applyStimulus(MREAD, 9'h005, 16'h0000, 16'hBEEF);

        // Reserved command: flags error, leaves read_data alone, no rd_valid
        pulseReset();
        applyStimulus(MREAD, 9'h005, 16'h0000, 16'hBEEF);
        applyStimulus(MRSVD, 9'h0FF, 16'h9999, 16'h0000);
        settle();
        checkOutput("rsvdErr", bus_err, 1);
        checkOutput("rsvdHold", read_data, 16'hBEEF);
        repeat (3) applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000);
        settle();
        checkOutput("errSticky", bus_err, 1);

        // Reset asserted while a read is in flight
        applyStimulus(MWRITE, 9'h100, 16'h00C3, 16'h0000);
        @(negedge clk);
        mem_cmd  = MREAD;
        mem_addr = 9'h005;
        @(posedge clk);
        #1;
        monitorOn = 1'b0;
        checkOutput("preRstValid", rd_valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("midRstReadData", read_data, 0);
        checkOutput("midRstRdValid", rd_valid, 0);
        checkOutput("midRstLedr", LEDR, 0);
        checkOutput("midRstBusErr", bus_err, 0);
        mem_cmd = MNONE;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        settle();
        sbQ.delete();
        monitorOn = 1'b1;
        repeat (4) applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000);
        settle();
        checkOutput("postRstReadData", read_data, 0);

        @(negedge clk);
        checkOutput("sbEmpty", sbQ.size(), 0);
        monitorOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
